uram_write_scheduler: RTL and testbench

Round-robin write scheduler and read-hazard guard in front of the multi-bank URAM XOR table. Grants one of NUM_REQ write requesters per cycle and drives the table's `write_reg_0_*` index/valid inputs and its 2-cycle-delayed `arbiter_result` / `write_reg_11_xor` inputs, keeping them time-aligned. Holds back table reads whose index matches a write still in flight, so reads never return stale data.

---
 rtl/uram_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/uram_write_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_uram_write_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_sched_pkg.sv
// Shared types and constants for the URAM write scheduler.
// Scoreboard entries carry indices zero-extended to SB_INDEX_MAX bits so the
// struct does not depend on the top-level INDEX_WIDTH parameter.
package uram_sched_pkg;

    // Grant cycle plus the four cycles until the table commits the write.
    localparam int WR_PIPE_DEPTH = 5;
    // Stages between write_reg_0_* and arbiter_result / write_reg_11_xor.
    localparam int WR_DATA_DELAY = 2;
    // Widest index the scoreboard entry can hold.
    localparam int SB_INDEX_MAX  = 32;

    typedef struct packed {
        logic                    valid;
        logic [SB_INDEX_MAX-1:0] index;
    } sb_entry_t;

    // True when a scoreboard entry holds a live write to the given index.
    function automatic logic sb_hit(input sb_entry_t e, input logic [SB_INDEX_MAX-1:0] idx);
        return e.valid && (e.index == idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Search starts one past the last granted requester;
// the pointer moves only when advance is high and a grant was issued.
// Reset points at NUM_REQ-1 so requester 0 has first priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] last_grant;
    logic [PTR_W-1:0] grant_idx;
    logic             found;
    int               idx;

    // Pick the first active requester after last_grant, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Pointer register: remembers the most recent winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PTR_W'(NUM_REQ - 1);
        end else if (advance && found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/uram_write_scheduler.sv
// Round-robin write scheduler and read-hazard guard for the multi-bank URAM
// XOR table. One write is granted per cycle; its index reaches the table one
// cycle later and its mask/data two cycles after that, matching the table's
// internal index delay. Reads are held back while a write to the same index
// is between grant and commit.
// Optional build macro: URAM_SCHED_PERF_CNT_EN adds saturating grant and
// read-stall counters.
module uram_write_scheduler
    import uram_sched_pkg::*;
#(
    parameter int NUM_MUL     = 4,
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LATENCY  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0]        req_index,
    input  logic [NUM_REQ*NUM_MUL-1:0]            req_mask,
    input  logic [NUM_REQ*NUM_MUL*DATA_WIDTH-1:0] req_data,
    output logic                                  write_reg_0_valid,
    output logic [INDEX_WIDTH-1:0]                write_reg_0_index,
    output logic [NUM_MUL-1:0]                    arbiter_result,
    output logic [NUM_MUL*DATA_WIDTH-1:0]         write_reg_11_xor,
    input  logic                                  rd_req_valid,
    input  logic [INDEX_WIDTH-1:0]                rd_req_index,
    output logic                                  rd_req_ready,
    output logic [INDEX_WIDTH-1:0]                rd_index,
    output logic                                  rd_data_valid
`ifdef URAM_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                           perf_wr_grants,
    output logic [31:0]                           perf_rd_stalls
`endif
);

    localparam int ROW_W = NUM_MUL * DATA_WIDTH;

    // Handshake: requester i transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; req_ready is combinational and one-hot or
    // zero, and a requester keeps its fields stable until it sees req_ready.

    logic [NUM_REQ-1:0]     grant;
    logic                   grant_any;
    logic [INDEX_WIDTH-1:0] win_index;
    logic [NUM_MUL-1:0]     win_mask;
    logic [ROW_W-1:0]       win_data;

    logic [NUM_MUL-1:0]     wr0_mask;
    logic [ROW_W-1:0]       wr0_data;
    logic                   dly_valid [WR_DATA_DELAY];
    logic [NUM_MUL-1:0]     dly_mask  [WR_DATA_DELAY];
    logic [ROW_W-1:0]       dly_data  [WR_DATA_DELAY];

    sb_entry_t              sb   [WR_PIPE_DEPTH];
    sb_entry_t              sb_q [1:WR_PIPE_DEPTH-1];
    logic                   rd_hit;
    logic [RD_LATENCY:0]    rd_pipe;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (grant_any),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign grant_any = |grant;

    // Select the winner's index, mask and data.
    always_comb begin
        win_index = '0;
        win_mask  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_index = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                win_mask  = req_mask[i*NUM_MUL +: NUM_MUL];
                win_data  = req_data[i*ROW_W +: ROW_W];
            end
        end
    end

    // First write stage: index/valid go straight to the table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg_0_valid <= 1'b0;
            write_reg_0_index <= '0;
            wr0_mask          <= '0;
            wr0_data          <= '0;
        end else begin
            write_reg_0_valid <= grant_any;
            write_reg_0_index <= win_index;
            wr0_mask          <= win_mask;
            wr0_data          <= win_data;
        end
    end

    // Mask/data delay line keeps bank enables aligned with the table's index pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WR_DATA_DELAY; k++) begin
                dly_valid[k] <= 1'b0;
                dly_mask[k]  <= '0;
                dly_data[k]  <= '0;
            end
        end else begin
            dly_valid[0] <= write_reg_0_valid;
            dly_mask[0]  <= wr0_mask;
            dly_data[0]  <= wr0_data;
            for (int k = 1; k < WR_DATA_DELAY; k++) begin
                dly_valid[k] <= dly_valid[k-1];
                dly_mask[k]  <= dly_mask[k-1];
                dly_data[k]  <= dly_data[k-1];
            end
        end
    end

    // Bubbles drive no bank enables and no data.
    assign arbiter_result   = dly_mask[WR_DATA_DELAY-1] & {NUM_MUL{dly_valid[WR_DATA_DELAY-1]}};
    assign write_reg_11_xor = dly_data[WR_DATA_DELAY-1] & {ROW_W{dly_valid[WR_DATA_DELAY-1]}};

    // Scoreboard view: entry 0 is this cycle's grant, the rest are registered.
    always_comb begin
        sb[0].valid = grant_any;
        sb[0].index = SB_INDEX_MAX'(win_index);
        for (int k = 1; k < WR_PIPE_DEPTH; k++) begin
            sb[k] = sb_q[k];
        end
    end

    // Scoreboard shift register: a write leaves once the table has committed it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < WR_PIPE_DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q[1] <= sb[0];
            for (int k = 2; k < WR_PIPE_DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // Read is accepted only when no in-flight write targets the same index.
    always_comb begin
        rd_hit = 1'b0;
        for (int k = 0; k < WR_PIPE_DEPTH; k++) begin
            rd_hit = rd_hit | sb_hit(sb[k], SB_INDEX_MAX'(rd_req_index));
        end
        rd_req_ready = rd_req_valid & ~rd_hit;
    end

    // Read index register and accept-pulse delay matching the table latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_index <= '0;
            rd_pipe  <= '0;
        end else begin
            if (rd_req_ready) begin
                rd_index <= rd_req_index;
            end
            rd_pipe <= {rd_pipe[RD_LATENCY-1:0], rd_req_ready};
        end
    end

    assign rd_data_valid = rd_pipe[RD_LATENCY];

`ifdef URAM_SCHED_PERF_CNT_EN
    // Saturating grant and read-stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_wr_grants <= '0;
            perf_rd_stalls <= '0;
        end else begin
            if (grant_any && (perf_wr_grants != '1)) begin
                perf_wr_grants <= perf_wr_grants + 32'd1;
            end
            if (rd_req_valid && !rd_req_ready && (perf_rd_stalls != '1)) begin
                perf_rd_stalls <= perf_rd_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uram_write_scheduler.sv
// Bench for uram_write_scheduler: directed scenarios plus random traffic,
// checked against a cycle-tagged reference model with expectation queues.
module tb_uram_write_scheduler;

    localparam int NUM_MUL    = 4;
    localparam int NUM_REQ    = 4;
    localparam int IW         = 12;
    localparam int DW         = 64;
    localparam int RDL        = 2;
    localparam int ROW_W      = NUM_MUL * DW;
    localparam int COMMIT_LAG = 4;  // write granted at G is committed at end of G+4

    logic                        clk;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*IW-1:0]       req_index;
    logic [NUM_REQ*NUM_MUL-1:0]  req_mask;
    logic [NUM_REQ*ROW_W-1:0]    req_data;
    logic                        write_reg_0_valid;
    logic [IW-1:0]               write_reg_0_index;
    logic [NUM_MUL-1:0]          arbiter_result;
    logic [ROW_W-1:0]            write_reg_11_xor;
    logic                        rd_req_valid;
    logic [IW-1:0]               rd_req_index;
    logic                        rd_req_ready;
    logic [IW-1:0]               rd_index;
    logic                        rd_data_valid;

    logic [IW-1:0]      rq_index [NUM_REQ];
    logic [NUM_MUL-1:0] rq_mask  [NUM_REQ];
    logic [ROW_W-1:0]   rq_data  [NUM_REQ];

    uram_write_scheduler #(
        .NUM_MUL     (NUM_MUL),
        .NUM_REQ     (NUM_REQ),
        .INDEX_WIDTH (IW),
        .DATA_WIDTH  (DW),
        .RD_LATENCY  (RDL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_index         (req_index),
        .req_mask          (req_mask),
        .req_data          (req_data),
        .write_reg_0_valid (write_reg_0_valid),
        .write_reg_0_index (write_reg_0_index),
        .arbiter_result    (arbiter_result),
        .write_reg_11_xor  (write_reg_11_xor),
        .rd_req_valid      (rd_req_valid),
        .rd_req_index      (rd_req_index),
        .rd_req_ready      (rd_req_ready),
        .rd_index          (rd_index),
        .rd_data_valid     (rd_data_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_index = '0;
        req_mask  = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_index[i*IW +: IW]           = rq_index[i];
            req_mask[i*NUM_MUL +: NUM_MUL]  = rq_mask[i];
            req_data[i*ROW_W +: ROW_W]      = rq_data[i];
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct { int cyc; logic [IW-1:0] index; } idx_exp_t;
    typedef struct { int cyc; logic [NUM_MUL-1:0] mask; logic [ROW_W-1:0] data; } row_exp_t;

    idx_exp_t exp_wr0_q[$];
    idx_exp_t exp_rdidx_q[$];
    idx_exp_t inflight_q[$];
    row_exp_t exp_row_q[$];
    int       exp_rdv_q[$];
    logic [NUM_REQ-1:0] fair_log[$];

    logic [IW-1:0]      exp_rd_index;
    int                 model_last;
    logic [NUM_REQ-1:0] grant_seen;
    logic [NUM_REQ-1:0] last_tick_grants;
    bit                 rd_seen;
    bit                 fair_rec;
    bit                 stall_rec;
    int                 stall_cnt;
    int                 auto_fill;
    int                 n_cmp = 0;
    int                 n_fail = 0;

    logic [NUM_REQ-1:0] m_gnt;
    int                 m_g;
    int                 m_idx;
    bit                 m_hit;
    bit                 m_acc;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        r = '0;
        for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: predicts grant and read accept each cycle and queues
    // the registered responses they cause, tagged with the cycle they appear.
    always @(negedge clk) begin
        if (!reset) begin
            m_gnt = '0;
            m_g   = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                m_idx = (model_last + k) % NUM_REQ;
                if (m_g < 0 && req_valid[m_idx]) begin
                    m_g = m_idx;
                    m_gnt[m_idx] = 1'b1;
                end
            end
            check("req_ready", ROW_W'(req_ready), ROW_W'(m_gnt));
            if (fair_rec) fair_log.push_back(req_ready);
            if (m_g >= 0) begin
                model_last     = m_g;
                grant_seen[m_g] = 1'b1;
                exp_wr0_q.push_back('{cyc: cyc + 1, index: rq_index[m_g]});
                exp_row_q.push_back('{cyc: cyc + 3, mask: rq_mask[m_g], data: rq_data[m_g]});
                inflight_q.push_back('{cyc: cyc, index: rq_index[m_g]});
            end
            while (inflight_q.size() > 0 && inflight_q[0].cyc < cyc - COMMIT_LAG)
                void'(inflight_q.pop_front());
            m_hit = 1'b0;
            foreach (inflight_q[k]) if (inflight_q[k].index == rd_req_index) m_hit = 1'b1;
            m_acc = rd_req_valid && !m_hit;
            check("rd_req_ready", ROW_W'(rd_req_ready), ROW_W'(m_acc));
            if (stall_rec && rd_req_valid && !rd_req_ready) stall_cnt++;
            if (m_acc) begin
                rd_seen = 1'b1;
                exp_rdidx_q.push_back('{cyc: cyc + 1, index: rd_req_index});
                exp_rdv_q.push_back(cyc + 1 + RDL);
            end
        end
    end

    // Monitor: compares registered outputs against queued expectations.
    always @(posedge clk) begin
        #3;
        if (exp_wr0_q.size() > 0 && exp_wr0_q[0].cyc == cyc) begin
            check("wr0_valid", ROW_W'(write_reg_0_valid), ROW_W'(1'b1));
            check("wr0_index", ROW_W'(write_reg_0_index), ROW_W'(exp_wr0_q[0].index));
            void'(exp_wr0_q.pop_front());
        end else begin
            check("wr0_valid_idle", ROW_W'(write_reg_0_valid), ROW_W'(1'b0));
        end
        if (exp_row_q.size() > 0 && exp_row_q[0].cyc == cyc) begin
            check("arbiter_result", ROW_W'(arbiter_result), ROW_W'(exp_row_q[0].mask));
            check("write_reg_11_xor", write_reg_11_xor, exp_row_q[0].data);
            void'(exp_row_q.pop_front());
        end else begin
            check("arbiter_result_idle", ROW_W'(arbiter_result), ROW_W'(0));
        end
        if (exp_rdidx_q.size() > 0 && exp_rdidx_q[0].cyc == cyc) begin
            exp_rd_index = exp_rdidx_q[0].index;
            void'(exp_rdidx_q.pop_front());
        end
        check("rd_index", ROW_W'(rd_index), ROW_W'(exp_rd_index));
        if (exp_rdv_q.size() > 0 && exp_rdv_q[0] == cyc) begin
            check("rd_data_valid", ROW_W'(rd_data_valid), ROW_W'(1'b1));
            void'(exp_rdv_q.pop_front());
        end else begin
            check("rd_data_valid_idle", ROW_W'(rd_data_valid), ROW_W'(1'b0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic new_req(input int i, input logic [IW-1:0] idx, input logic [NUM_MUL-1:0] mask);
        req_valid[i] = 1'b1;
        rq_index[i]  = idx;
        rq_mask[i]   = mask;
        rq_data[i]   = rand_row();
    endtask

    // Advance one cycle; retire accepted requests and refill per auto_fill.
    task automatic tick();
        @(posedge clk);
        #1;
        last_tick_grants = grant_seen;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_seen[i]) begin
                grant_seen[i] = 1'b0;
                req_valid[i]  = 1'b0;
            end
        end
        if (rd_seen) begin
            rd_seen      = 1'b0;
            rd_req_valid = 1'b0;
        end
        if (auto_fill == 1) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i]) new_req(i, IW'($urandom_range(0, 255)), NUM_MUL'($urandom));
        end else if (auto_fill == 2) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] && $urandom_range(0, 99) < 50)
                    new_req(i, IW'($urandom_range(0, 7)), NUM_MUL'($urandom));
            if (!rd_req_valid && $urandom_range(0, 99) < 60) begin
                rd_req_valid = 1'b1;
                rd_req_index = IW'($urandom_range(0, 7));
            end
        end
    endtask

    // Called right after a tick; clears the model and holds reset two cycles.
    task automatic reset_now();
        auto_fill    = 0;
        exp_wr0_q.delete();
        exp_rdidx_q.delete();
        inflight_q.delete();
        exp_row_q.delete();
        exp_rdv_q.delete();
        model_last   = NUM_REQ - 1;
        exp_rd_index = '0;
        grant_seen   = '0;
        rd_seen      = 1'b0;
        req_valid    = '0;
        rd_req_valid = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((req_valid != '0 || rd_req_valid) && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", ROW_W'((req_valid != '0) || rd_req_valid), ROW_W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        rd_req_valid = 1'b0;
        rd_req_index = '0;
        grant_seen   = '0;
        last_tick_grants = '0;
        rd_seen      = 1'b0;
        fair_rec     = 1'b0;
        stall_rec    = 1'b0;
        stall_cnt    = 0;
        auto_fill    = 0;
        model_last   = NUM_REQ - 1;
        exp_rd_index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_index[i] = '0;
            rq_mask[i]  = '0;
            rq_data[i]  = '0;
        end
        repeat (3) tick();
        reset = 1'b0;

        // Lone write
        tick();
        new_req(0, 12'h012, 4'b0101);
        wait_idle();
        repeat (6) tick();

        // Fairness from a fresh reset
        tick();
        reset_now();
        fair_log.delete();
        for (int i = 0; i < NUM_REQ; i++) new_req(i, IW'($urandom_range(0, 255)), NUM_MUL'($urandom));
        fair_rec  = 1'b1;
        auto_fill = 1;
        repeat (8) tick();
        fair_rec  = 1'b0;
        auto_fill = 0;
        check("fair_count", ROW_W'(fair_log.size()), ROW_W'(8));
        for (int k = 0; k < fair_log.size() && k < 8; k++)
            check("fair_order", ROW_W'(fair_log[k]), ROW_W'(1 << (k % NUM_REQ)));
        wait_idle();
        repeat (6) tick();

        // Read-after-write hazard: blocked for the grant cycle plus four
        stall_cnt = 0;
        stall_rec = 1'b1;
        new_req(1, 12'h040, 4'b1111);
        rd_req_valid = 1'b1;
        rd_req_index = 12'h040;
        wait_idle();
        stall_rec = 1'b0;
        check("raw_stall_cycles", ROW_W'(stall_cnt), ROW_W'(5));
        repeat (6) tick();

        // Non-conflicting read alongside an in-flight write
        stall_cnt = 0;
        stall_rec = 1'b1;
        new_req(2, 12'h040, 4'b0011);
        rd_req_valid = 1'b1;
        rd_req_index = 12'h041;
        wait_idle();
        stall_rec = 1'b0;
        check("nc_stall_cycles", ROW_W'(stall_cnt), ROW_W'(0));
        repeat (6) tick();

        // Zero-mask write still consumes a slot and moves the pointer
        new_req(3, 12'h077, 4'b0000);
        wait_idle();
        for (int i = 0; i < NUM_REQ; i++) new_req(i, IW'($urandom_range(0, 255)), NUM_MUL'($urandom));
        wait_idle();
        repeat (6) tick();

        // Reset two cycles after a grant
        new_req(2, 12'h055, 4'b1010);
        begin
            int n;
            n = 0;
            tick();
            while (last_tick_grants[2] == 1'b0 && n < 20) begin
                tick();
                n++;
            end
            check("midflight_grant", ROW_W'(last_tick_grants[2]), ROW_W'(1'b1));
        end
        tick();
        reset_now();
        for (int i = 0; i < NUM_REQ; i++) new_req(i, IW'($urandom_range(0, 255)), NUM_MUL'($urandom));
        rd_req_valid = 1'b1;
        rd_req_index = 12'h055;
        @(negedge clk);
        #1;
        check("post_reset_grant", ROW_W'(req_ready), ROW_W'(4'b0001));
        check("post_reset_read", ROW_W'(rd_req_ready), ROW_W'(1'b1));
        wait_idle();
        repeat (6) tick();

        // Random traffic over a small index range to provoke hazards
        auto_fill = 2;
        repeat (1500) tick();
        auto_fill = 0;
        wait_idle();
        repeat (10) tick();
        check("leftover_expectations",
              ROW_W'(exp_wr0_q.size() + exp_row_q.size() + exp_rdv_q.size() + exp_rdidx_q.size()),
              ROW_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
